// File: rtl/meteor_spawner.sv
// Meteor spawner for the dodge game.
// Keeps six meteor slots that fall down the 640x480 screen, spawns new
// meteors at pseudo-random horizontal positions, counts the meteors the
// player dodged and ends the game when an active meteor is hit.

module meteor_spawner #(
   parameter int          FALL_SPEED     = 2,
   parameter int          SPAWN_INTERVAL = 45,
   parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_tick,
   input  logic       start,
   input  logic [5:0] meteor_collisions,
   output logic [9:0] meteor_x [6],
   output logic [8:0] meteor_y [6],
   output logic [5:0] meteor_active,
   output logic       game_over,
   output logic       dodged_pulse,
   output logic [7:0] dodged_count
);

   localparam logic [9:0] Y_LIMIT   = 10'd450;
   localparam logic [9:0] X_RANGE   = 10'd611;
   localparam logic [9:0] FALL_STEP = 10'(FALL_SPEED);
   localparam logic [7:0] CNT_LAST  = 8'(SPAWN_INTERVAL - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      OVER
   } state_t;

   state_t      state_q;
   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;
   logic [5:0]  active_q;
   logic [9:0]  meteorX_q [6];
   logic [8:0]  meteorY_q [6];
   logic [7:0]  spawnCnt_q;
   logic [7:0]  dodgedCount_q;
   logic        dodgedPulse_q;
   logic        gameOver_q;

   logic [9:0]  ySum [6];
   logic [5:0]  exitMask;
   logic [2:0]  exitCount;
   logic        freeFound;
   logic [2:0]  freeIdx;
   logic [9:0]  spawnX;
   logic [8:0]  dodgeSum;
   logic [7:0]  dodgedCount_d;
   logic        hit;
   logic        spawnAttempt;
   logic [5:0]  active_d;
   logic [9:0]  meteorX_d [6];
   logic [8:0]  meteorY_d [6];
   logic [7:0]  spawnCnt_d;

   // The position generator is a 16-bit Fibonacci LFSR (taps 16,14,13,11)
   // shifting left; the new bit enters at the bottom. Only a hit on a slot
   // that is actually live counts, stale collision bits from empty slots
   // are ignored.
   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      hit    = |(meteor_collisions & active_q);
   end

   // Work out what a frame tick in RUN would do to every slot: move the
   // live meteors down (10-bit sum so nothing wraps), retire the ones that
   // would pass the bottom, and count how many were retired. The free slot
   // search looks at the flags as they were before this tick, so a slot
   // retired on this very tick cannot be reused until the next one.
   always_comb begin
      exitMask  = '0;
      exitCount = '0;
      freeFound = 1'b0;
      freeIdx   = '0;
      for (int i = 0; i < 6; i++) begin
         ySum[i]     = {1'b0, meteorY_q[i]} + FALL_STEP;
         exitMask[i] = active_q[i] && (ySum[i] > Y_LIMIT);
         exitCount   = exitCount + 3'(exitMask[i]);
      end
      for (int i = 5; i >= 0; i--) begin
         if (!active_q[i]) begin
            freeFound = 1'b1;
            freeIdx   = 3'(i);
         end
      end
      spawnX        = (lfsr_q[9:0] < X_RANGE) ? lfsr_q[9:0] : (lfsr_q[9:0] - X_RANGE);
      dodgeSum      = {1'b0, dodgedCount_q} + {6'b0, exitCount};
      dodgedCount_d = dodgeSum[8] ? 8'hFF : dodgeSum[7:0];
   end

   // Build the complete next slot state for a RUN frame tick. The spawn
   // counter advances each tick until it sits on its last value; from then
   // on every tick is a spawn attempt, and it only returns to zero once a
   // meteor has actually been placed.
   always_comb begin
      spawnAttempt = (spawnCnt_q == CNT_LAST);
      active_d     = active_q;
      meteorX_d    = meteorX_q;
      meteorY_d    = meteorY_q;
      spawnCnt_d   = spawnCnt_q;
      for (int i = 0; i < 6; i++) begin
         if (active_q[i] && !exitMask[i]) begin
            meteorY_d[i] = ySum[i][8:0];
         end
         if (exitMask[i]) begin
            active_d[i] = 1'b0;
         end
      end
      if (spawnAttempt) begin
         if (freeFound) begin
            active_d[freeIdx]  = 1'b1;
            meteorX_d[freeIdx] = spawnX;
            meteorY_d[freeIdx] = '0;
            spawnCnt_d         = '0;
         end
      end else begin
         spawnCnt_d = spawnCnt_q + 8'd1;
      end
   end

   // Game state machine and all registered state. The LFSR runs every
   // cycle regardless of state. Starting a game wipes the slots and the
   // score; a live hit freezes everything and wins over a coincident frame
   // tick, so nothing moves, exits or spawns on that cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         lfsr_q        <= LFSR_SEED;
         active_q      <= '0;
         meteorX_q     <= '{default: '0};
         meteorY_q     <= '{default: '0};
         spawnCnt_q    <= '0;
         dodgedCount_q <= '0;
         dodgedPulse_q <= 1'b0;
         gameOver_q    <= 1'b0;
      end else begin
         lfsr_q        <= lfsr_d;
         dodgedPulse_q <= 1'b0;
         case (state_q)
            IDLE, OVER: begin
               if (start) begin
                  state_q       <= RUN;
                  gameOver_q    <= 1'b0;
                  active_q      <= '0;
                  meteorX_q     <= '{default: '0};
                  meteorY_q     <= '{default: '0};
                  spawnCnt_q    <= '0;
                  dodgedCount_q <= '0;
               end
            end
            RUN: begin
               if (hit) begin
                  state_q    <= OVER;
                  gameOver_q <= 1'b1;
               end else if (frame_tick) begin
                  active_q      <= active_d;
                  meteorX_q     <= meteorX_d;
                  meteorY_q     <= meteorY_d;
                  spawnCnt_q    <= spawnCnt_d;
                  dodgedCount_q <= dodgedCount_d;
                  dodgedPulse_q <= |exitMask;
               end
            end
            default: begin
               state_q    <= IDLE;
               gameOver_q <= 1'b0;
            end
         endcase
      end
   end

   assign meteor_x      = meteorX_q;
   assign meteor_y      = meteorY_q;
   assign meteor_active = active_q;
   assign game_over     = gameOver_q;
   assign dodged_pulse  = dodgedPulse_q;
   assign dodged_count  = dodgedCount_q;

endmodule
